// File: rtl/sub_bytes_serial_if.sv
// Start/done handshake bundle for the serial AES forward SubBytes engine.
interface sub_bytes_serial_if;
    logic         start;
    logic [127:0] data_in;
    logic         busy;
    logic         done;
    logic [127:0] data_out;

    modport master (output start, data_in, input busy, done, data_out);
    modport slave  (input start, data_in, output busy, done, data_out);
endinterface

// File: rtl/sub_bytes_serial.sv
// AES forward SubBytes over a 128-bit state, BPC S-box lanes reused over 16/BPC cycles.
// Byte 0 is the most significant byte of the state.
module sub_bytes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y = SBOX[a];
endmodule

module sub_bytes_serial #(
    parameter int BPC = 1
) (
    input  logic              clk,
    input  logic              rst,
    sub_bytes_serial_if.slave bus
);
    localparam int N  = 16 / BPC;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef logic [0:N-1][0:BPC-1][7:0] state_arr_t;
    typedef enum logic {IDLE, RUN} state_t;

    if (BPC != 1 && BPC != 2 && BPC != 4 && BPC != 8 && BPC != 16) begin : g_bpc_chk
        $error("sub_bytes_serial: BPC must be 1, 2, 4, 8 or 16");
    end

    state_t             state, state_nx;
    state_arr_t         work, work_nx;
    logic [CW-1:0]      cnt, cnt_nx;
    logic [127:0]       dout, dout_nx;
    logic               done, done_nx;
    logic               busy, busy_nx;
    logic [0:BPC-1][7:0] grp_in, grp_out;
    logic               last;

    assign last = (cnt == CW'(N - 1));

    // Group select mux feeding the shared S-box lanes
    always_comb begin
        grp_in = work[0];
        for (int g = 0; g < N; g++)
            if (cnt == CW'(g)) grp_in = work[g];
    end

    for (genvar j = 0; j < BPC; j++) begin : g_lane
        sub_bytes_sbox u_sbox (.a(grp_in[j]), .y(grp_out[j]));
    end

    always_comb begin
        state_nx = state;
        work_nx  = work;
        cnt_nx   = cnt;
        dout_nx  = dout;
        done_nx  = 1'b0;
        busy_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    work_nx  = bus.data_in;
                    cnt_nx   = '0;
                    busy_nx  = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                for (int g = 0; g < N; g++)
                    if (cnt == CW'(g)) work_nx[g] = grp_out;
                cnt_nx  = cnt + 1'b1;
                busy_nx = 1'b1;
                if (last) begin
                    // Publish the state including the group substituted this edge
                    dout_nx  = work_nx;
                    done_nx  = 1'b1;
                    busy_nx  = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            work  <= '0;
            cnt   <= '0;
            dout  <= '0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            work  <= work_nx;
            cnt   <= cnt_nx;
            dout  <= dout_nx;
            done  <= done_nx;
            busy  <= busy_nx;
        end
    end

    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.data_out = dout;
endmodule
